// File: rtl/pciecfg_pkg.sv
// Shared types and helpers for the soft PCIe configuration space.
package pciecfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_DONE    = 3'd3,
        ST_RECOVER = 3'd4
    } pciecfg_space_state_t;

    // DWORDs that ignore writes: the ID/command/class header and DW 0x0F.
    localparam int PCIECFG_RO_DW_N = 5;
    localparam logic [9:0] PCIECFG_RO_DW [PCIECFG_RO_DW_N] =
        '{10'h000, 10'h001, 10'h002, 10'h003, 10'h00F};

    function automatic logic pciecfg_dw_writable(input logic [9:0] dwaddr);
        logic w;
        w = 1'b1;
        for (int i = 0; i < PCIECFG_RO_DW_N; i++) begin
            if (dwaddr == PCIECFG_RO_DW[i]) w = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [31:0] pciecfg_be_merge(input logic [31:0] old_dw,
                                                     input logic [31:0] new_dw,
                                                     input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_dw[8*i +: 8] : old_dw[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/pciecfg_space_ram.sv
// NUM_DW x 32 configuration array: one byte-merging write port, one registered read port.
module pciecfg_space_ram
    import pciecfg_pkg::*;
#(
    parameter  int          NUM_DW   = 64,
    parameter  logic [31:0] INIT_DW0 = 32'h0,
    localparam int          AW       = $clog2(NUM_DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          rzero,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NUM_DW];

    // Array contents: DW0 carries the IDs out of reset, everything else clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DW; i++) begin
                mem[i] <= (i == 0) ? INIT_DW0 : 32'h0;
            end
        end else if (we) begin
            mem[waddr] <= pciecfg_be_merge(mem[waddr], wdata, wbe);
        end
    end

    // Read register only moves on a read completion, so it holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= rzero ? 32'h0 : mem[raddr];
        end
    end

endmodule

// File: rtl/pciecfg_space_model.sv
// Completer side of the cfg_mgmt handshake in front of a small soft config space.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for rd_en / wr_en (write wins if both)
//   RD_WAIT    | read accepted, latency counter running down
//   WR_WAIT    | write accepted, latency counter running down
//   DONE       | one-cycle done pulse, do valid
//   RECOVER    | waiting for the initiator to drop both enables
module pciecfg_space_model
    import pciecfg_pkg::*;
#(
    parameter int          NUM_DW     = 64,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1,
    parameter logic [15:0] VENDOR_ID  = 16'h10EE,
    parameter logic [15:0] DEVICE_ID  = 16'h7028
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  cfg_mgmt_dwaddr,
    input  logic        cfg_mgmt_rd_en,
    input  logic        cfg_mgmt_wr_en,
    input  logic [3:0]  cfg_mgmt_byte_en,
    input  logic [31:0] cfg_mgmt_di,
    output logic [31:0] cfg_mgmt_do,
    output logic        cfg_mgmt_rd_wr_done,
    output logic        proto_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [7:0]  abort_count
);

    localparam int         AW      = $clog2(NUM_DW);
    localparam logic [2:0] RD_LOAD = 3'(RD_LATENCY - 1);
    localparam logic [2:0] WR_LOAD = 3'(WR_LATENCY - 1);

    pciecfg_space_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q;
    logic [3:0]  be_q;
    logic [31:0] di_q;
    logic        load, ram_we, ram_re, done_d;
    logic        inc_rd, inc_wr, inc_abort, set_perr;
    logic        in_range;

    assign in_range = ({1'b0, addr_q} < 11'(NUM_DW));

    pciecfg_space_ram #(
        .NUM_DW   (NUM_DW),
        .INIT_DW0 ({DEVICE_ID, VENDOR_ID})
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (addr_q[AW-1:0]),
        .wdata (di_q),
        .wbe   (be_q),
        .re    (ram_re),
        .raddr (addr_q[AW-1:0]),
        .rzero (!in_range),
        .rdata (cfg_mgmt_do)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and per-cycle strobes; an abort takes priority over completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        done_d    = 1'b0;
        inc_rd    = 1'b0;
        inc_wr    = 1'b0;
        inc_abort = 1'b0;
        set_perr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_mgmt_wr_en) begin
                    load     = 1'b1;
                    cnt_d    = WR_LOAD;
                    set_perr = cfg_mgmt_rd_en;
                    state_d  = ST_WR_WAIT;
                end else if (cfg_mgmt_rd_en) begin
                    load    = 1'b1;
                    cnt_d   = RD_LOAD;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (!cfg_mgmt_rd_en) begin
                    inc_abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    ram_re  = 1'b1;
                    done_d  = 1'b1;
                    inc_rd  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WR_WAIT: begin
                if (!cfg_mgmt_wr_en) begin
                    inc_abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    ram_we  = in_range && pciecfg_dw_writable(addr_q);
                    done_d  = 1'b1;
                    inc_wr  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (!cfg_mgmt_rd_en && !cfg_mgmt_wr_en) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 10'h0;
            be_q   <= 4'h0;
            di_q   <= 32'h0;
        end else if (load) begin
            addr_q <= cfg_mgmt_dwaddr;
            be_q   <= cfg_mgmt_byte_en;
            di_q   <= cfg_mgmt_di;
        end
    end

    // Registered done pulse, sticky protocol error and wrapping statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mgmt_rd_wr_done <= 1'b0;
            proto_err           <= 1'b0;
            rd_count            <= 16'h0;
            wr_count            <= 16'h0;
            abort_count         <= 8'h0;
        end else begin
            cfg_mgmt_rd_wr_done <= done_d;
            if (set_perr)  proto_err   <= 1'b1;
            if (inc_rd)    rd_count    <= rd_count + 16'd1;
            if (inc_wr)    wr_count    <= wr_count + 16'd1;
            if (inc_abort) abort_count <= abort_count + 8'd1;
        end
    end

endmodule
